// File: rtl/smac_quant_sched.sv
// Shared quantization/write-back scheduler: grants one accumulator lane at a time,
// drives its shift enable, hands it to write-back, then clears it. Optional macro: SMAC_QSCHED_RR_EN.
module smac_quant_sched #(
  parameter  int Pa = 8,
  parameter  int Pw = 8,
  parameter  int NL = 4,
  localparam int SW = $clog2(Pa*Pw),
  localparam int LW = $clog2(NL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_load,
  input  logic [SW-1:0] cfg_shift,
  input  logic [NL-1:0] lane_done,
  output logic [NL-1:0] lane_shift_en,
  output logic [NL-1:0] lane_clear,
  output logic          wb_valid,
  output logic [LW-1:0] wb_lane,
  input  logic          wb_ready,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WB, S_CLR} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [SW-1:0] r_shadow_shift;
  logic [SW-1:0] r_act_shift;
  logic [SW-1:0] r_cnt;
  logic [LW-1:0] r_gnt;
  logic [LW-1:0] w_sel;
  logic          w_any;
  logic [NL-1:0] w_gnt_oh;

  assign w_any    = |lane_done;
  assign w_gnt_oh = NL'(1) << r_gnt;

`ifdef SMAC_QSCHED_RR_EN
  logic [LW-1:0] r_rr_ptr;
  logic          w_found;

  // First requesting lane at or above the pointer, wrapping past NL-1.
  always_comb begin
    int idx;
    w_sel   = '0;
    w_found = 1'b0;
    idx     = 0;
    for (int k = 0; k < NL; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NL) idx = idx - NL;
      if (!w_found && lane_done[idx]) begin
        w_sel   = LW'(idx);
        w_found = 1'b1;
      end
    end
  end
`else
  // Fixed priority: the lowest requesting index wins.
  always_comb begin
    w_sel = '0;
    for (int i = NL - 1; i >= 0; i--) begin
      if (lane_done[i]) w_sel = LW'(i);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_shadow_shift <= '0;
      r_act_shift    <= '0;
      r_cnt          <= '0;
      r_gnt          <= '0;
`ifdef SMAC_QSCHED_RR_EN
      r_rr_ptr       <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      if (cfg_load) r_shadow_shift <= cfg_shift;
      case (r_state)
        S_IDLE: begin
          // Grant samples the shadow value before any same-cycle cfg_load lands.
          if (w_any) begin
            r_gnt       <= w_sel;
            r_act_shift <= r_shadow_shift;
            r_cnt       <= '0;
          end
        end
        S_SHIFT: r_cnt <= r_cnt + SW'(1);
        S_CLR: begin
`ifdef SMAC_QSCHED_RR_EN
          r_rr_ptr <= (r_gnt == LW'(NL - 1)) ? '0 : r_gnt + LW'(1);
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any) w_state_next = (r_shadow_shift != '0) ? S_SHIFT : S_WB;
      end
      S_SHIFT: begin
        if (r_cnt == r_act_shift - SW'(1)) w_state_next = S_WB;
      end
      S_WB: begin
        if (wb_ready) w_state_next = S_CLR;
      end
      S_CLR:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs depend only on registered state, never on inputs.
  always_comb begin
    lane_shift_en = '0;
    lane_clear    = '0;
    wb_valid      = 1'b0;
    wb_lane       = '0;
    busy          = (r_state != S_IDLE);
    case (r_state)
      S_SHIFT: lane_shift_en = w_gnt_oh;
      S_WB: begin
        wb_valid = 1'b1;
        wb_lane  = r_gnt;
      end
      S_CLR:   lane_clear = w_gnt_oh;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_smac_quant_sched.sv
// Directed bench for smac_quant_sched (NL=4, SW=6); expectations follow the
// selected arbitration mode (SMAC_QSCHED_RR_EN).
module tb_smac_quant_sched;

  logic       clk;
  logic       rst_n;
  logic       cfg_load;
  logic [5:0] cfg_shift;
  logic [3:0] lane_done;
  logic [3:0] lane_shift_en;
  logic [3:0] lane_clear;
  logic       wb_valid;
  logic [1:0] wb_lane;
  logic       wb_ready;
  logic       busy;

  int checks;
  int errors;

  smac_quant_sched #(.Pa(8), .Pw(8), .NL(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_load     (cfg_load),
    .cfg_shift    (cfg_shift),
    .lane_done    (lane_done),
    .lane_shift_en(lane_shift_en),
    .lane_clear   (lane_clear),
    .wb_valid     (wb_valid),
    .wb_lane      (wb_lane),
    .wb_ready     (wb_ready),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
  endtask

  task automatic load_cfg(input logic [5:0] val);
    cfg_load  = 1'b1;
    cfg_shift = val;
    step();
  endtask

  // Serve one granted lane starting from IDLE with its request already raised.
  task automatic serve(input int lane, input int nsh, input int wait_cyc,
                       input int load_at, input logic [5:0] load_val, input string tag);
    logic [3:0] oh;
    int         busy_cnt;
    oh       = 4'b0001 << lane;
    busy_cnt = 0;
    wb_ready = 1'b0;
    step();
    for (int k = 0; k < nsh; k++) begin
      check({tag, " shift_en"}, 32'(lane_shift_en), 32'(oh));
      check({tag, " wb_valid_early"}, 32'(wb_valid), 32'd0);
      if (busy) busy_cnt++;
      if (k == load_at) begin
        cfg_load  = 1'b1;
        cfg_shift = load_val;
      end
      step();
    end
    check({tag, " wb_valid"}, 32'(wb_valid), 32'd1);
    check({tag, " wb_lane"}, 32'(wb_lane), 32'(lane));
    check({tag, " shift_en_off"}, 32'(lane_shift_en), 32'd0);
    if (busy) busy_cnt++;
    for (int w = 0; w < wait_cyc; w++) begin
      step();
      check({tag, " wb_valid_hold"}, 32'(wb_valid), 32'd1);
      check({tag, " wb_lane_hold"}, 32'(wb_lane), 32'(lane));
      check({tag, " clear_early"}, 32'(lane_clear), 32'd0);
      if (busy) busy_cnt++;
    end
    wb_ready = 1'b1;
    step();
    check({tag, " lane_clear"}, 32'(lane_clear), 32'(oh));
    check({tag, " wb_valid_drop"}, 32'(wb_valid), 32'd0);
    if (busy) busy_cnt++;
    lane_done = lane_done & ~oh;
    wb_ready  = 1'b0;
    step();
    check({tag, " clear_pulse"}, 32'(lane_clear), 32'd0);
    check({tag, " idle"}, 32'(busy), 32'd0);
    // busy covers SHIFT, WB and CLR but not the IDLE grant cycle
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(nsh + wait_cyc + 2));
    $display("served lane %0d: %0d shifts, %0d wb stalls", lane, nsh, wait_cyc);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    cfg_load  = 1'b0;
    cfg_shift = '0;
    lane_done = '0;
    wb_ready  = 1'b0;
    repeat (3) step();
    check("rst shift_en", 32'(lane_shift_en), 32'd0);
    check("rst clear", 32'(lane_clear), 32'd0);
    check("rst wb_valid", 32'(wb_valid), 32'd0);
    check("rst wb_lane", 32'(wb_lane), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();

    // Single lane with five shift cycles
    load_cfg(6'd5);
    lane_done = 4'b0100;
    serve(2, 5, 0, -1, 6'd0, "single");

    // Zero shift goes straight to write-back
    load_cfg(6'd0);
    lane_done = 4'b0001;
    serve(0, 0, 0, -1, 6'd0, "zero");

    // Back-pressure for ten cycles
    load_cfg(6'd2);
    lane_done = 4'b0010;
    serve(1, 2, 10, -1, 6'd0, "bp");

    // Reload during SHIFT only affects the next grant
    load_cfg(6'd4);
    lane_done = 4'b0010;
    serve(1, 4, 0, 1, 6'd63, "cfg_mid");
    lane_done = 4'b1000;
    serve(3, 63, 0, -1, 6'd0, "cfg_next");

    // All lanes requesting, pointer at 0 in either mode
    load_cfg(6'd3);
    lane_done = 4'b1111;
    serve(0, 3, 0, -1, 6'd0, "arb0");
    serve(1, 3, 0, -1, 6'd0, "arb1");
    serve(2, 3, 0, -1, 6'd0, "arb2");
    serve(3, 3, 0, -1, 6'd0, "arb3");

    // Lane 0 re-raises right after its clear
    lane_done = 4'b0011;
    serve(0, 3, 0, -1, 6'd0, "rr_first");
    lane_done[0] = 1'b1;
`ifdef SMAC_QSCHED_RR_EN
    serve(1, 3, 0, -1, 6'd0, "rr_next");
    serve(0, 3, 0, -1, 6'd0, "rr_last");
`else
    serve(0, 3, 0, -1, 6'd0, "fp_next");
    serve(1, 3, 0, -1, 6'd0, "fp_last");
`endif

    // cfg_load coinciding with a grant: old value used, new one next time
    load_cfg(6'd2);
    cfg_load  = 1'b1;
    cfg_shift = 6'd3;
    lane_done = 4'b0001;
    serve(0, 2, 0, -1, 6'd0, "same_cyc");
    lane_done = 4'b0100;
    serve(2, 3, 0, -1, 6'd0, "after_same");

    // Reset during the third enable cycle
    load_cfg(6'd5);
    lane_done = 4'b0100;
    step();
    step();
    step();
    check("pre_rst shift_en", 32'(lane_shift_en), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    check("async shift_en", 32'(lane_shift_en), 32'd0);
    check("async clear", 32'(lane_clear), 32'd0);
    check("async wb_valid", 32'(wb_valid), 32'd0);
    check("async wb_lane", 32'(wb_lane), 32'd0);
    check("async busy", 32'(busy), 32'd0);
    step();
    check("held_rst busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    // shadow_shift was cleared by reset, so the re-grant carries zero shifts
    serve(2, 0, 0, -1, 6'd0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
